// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier family (state encoding, counter sizing helper).
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mult_state_t;

    localparam int unsigned STATE_W = 2;

    // Iteration counter width; a 1-bit floor keeps degenerate widths legal.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM and iteration counter for the shift-add multiplier.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    output mult_state_t                    state_o,
    output logic [cnt_width(WIDTH)-1:0]    count_o,
    output logic                           accept_c_o,
    output logic                           last_iter_c_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    mult_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    assign accept_c_o    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_iter_c_o = (state_q == ST_COMPUTE) && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_COMPUTE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (last_iter_c_o) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Status flags are decoded from the next state so they line up with state_q.
        busy_d = (state_d == ST_COMPUTE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign count_o = cnt_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, runtime signed/unsigned mode.
module seq_mult_param
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   y_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [STATE_W-1:0]   state_o
);

    localparam int unsigned P_W   = 2 * WIDTH;
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    mult_state_t        state;
    logic [CNT_W-1:0]   count;
    logic               accept_c;
    logic               last_iter_c;

    logic [WIDTH-1:0]   amag_q, amag_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic               neg_q, neg_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [P_W-1:0]     y_q, y_d;

    logic [WIDTH-1:0]   amag_c, bmag_c;
    logic [P_W-1:0]     pp_c, sum_c;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .state_o       (state),
        .count_o       (count),
        .accept_c_o    (accept_c),
        .last_iter_c_o (last_iter_c),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    // Operand magnitudes; -2^(WIDTH-1) maps onto itself, which read unsigned is the correct magnitude.
    assign amag_c = (signed_i && a_i[WIDTH-1]) ? WIDTH'(~a_i + WIDTH'(1)) : a_i;
    assign bmag_c = (signed_i && b_i[WIDTH-1]) ? WIDTH'(~b_i + WIDTH'(1)) : b_i;

    assign pp_c  = bmag_q[count] ? (P_W'(amag_q) << count) : '0;
    assign sum_c = acc_q + pp_c;

    always_comb begin
        amag_d = amag_q;
        bmag_d = bmag_q;
        neg_d  = neg_q;
        acc_d  = acc_q;
        y_d    = y_q;
        if (accept_c) begin
            amag_d = amag_c;
            bmag_d = bmag_c;
            neg_d  = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            acc_d  = '0;
        end else if (state == ST_COMPUTE) begin
            acc_d = sum_c;
            if (last_iter_c) begin
                y_d = neg_q ? P_W'(~sum_c + P_W'(1)) : sum_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            amag_q <= '0;
            bmag_q <= '0;
            neg_q  <= 1'b0;
            acc_q  <= '0;
            y_q    <= '0;
        end else begin
            amag_q <= amag_d;
            bmag_q <= bmag_d;
            neg_q  <= neg_d;
            acc_q  <= acc_d;
            y_q    <= y_d;
        end
    end

    assign y_o     = y_q;
    assign state_o = state;

endmodule
